// File: rtl/adder_bist_pkg.sv
// Shared constants and FSM state encoding for the 8-bit adder BIST checker.
package adder_bist_pkg;

  localparam int WIDTH       = 8;
  localparam int LFSR_W      = 17;
  // Fibonacci taps for x^17 + x^14 + 1 (zero-based bit positions).
  localparam int LFSR_TAP_HI = 16;
  localparam int LFSR_TAP_LO = 13;
  localparam int MISR_W      = 16;
  // x^16 + x^12 + x^5 + 1, the x^16 term being implicit in the shift.
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/lfsr17.sv
// 17-bit Fibonacci LFSR pattern generator; a zero seed falls back to 17'h00001.
module lfsr17
  import adder_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 17'h00001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 17'h00001 : SEED;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= SEED_EFF;
    end else if (step) begin
      value <= {value[LFSR_W-2:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/adder_bist_checker.sv
// BIST sequencer for an external 8-bit adder: drives LFSR vectors, checks responses.
// Optional response MISR enabled by defining BIST_SIGNATURE_EN.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int               N_VECTORS     = 256,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [LFSR_W-1:0] SEED         = 17'h00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      first_fail_idx,
  output logic [15:0]      signature
);

  localparam logic [15:0] LAST_IDX  = 16'(N_VECTORS - 1);
  localparam logic [3:0]  WAIT_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [15:0]       vec_idx;
  logic [3:0]        wait_cnt;
  logic [WIDTH:0]    expected;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              mismatch;
  logic              is_last;

  // start is only honoured from IDLE/DONE; the enclosing reset branch masks it under rst.
  assign lfsr_load = (state == IDLE || state == DONE) && start;
  assign is_last   = (vec_idx == LAST_IDX);
  assign lfsr_step = (state == CHECK) && !is_last;
  assign mismatch  = ({cout_in, sum_in} != expected);

  lfsr17 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      a              <= '0;
      b              <= '0;
      cin            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 16'hFFFF;
      vec_idx        <= '0;
      wait_cnt       <= '0;
      expected       <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DRIVE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_idx        <= '0;
            err_count      <= '0;
            first_fail_idx <= 16'hFFFF;
          end else if (state == DONE) begin
            // Counters are final by now, so done/pass publish one cycle after entry.
            done <= 1'b1;
            pass <= (err_count == 8'd0);
          end
        end
        DRIVE: begin
          a        <= lfsr[7:0];
          b        <= lfsr[15:8];
          cin      <= lfsr[16];
          expected <= {1'b0, lfsr[7:0]} + {1'b0, lfsr[15:8]} + {8'b0, lfsr[16]};
          wait_cnt <= WAIT_INIT;
          state    <= (SETTLE_CYCLES == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= CHECK;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF)         err_count      <= err_count + 8'd1;
            if (first_fail_idx == 16'hFFFF) first_fail_idx <= vec_idx;
          end
          if (is_last) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            vec_idx <= vec_idx + 16'd1;
            state   <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIST_SIGNATURE_EN
  logic [MISR_W-1:0] misr;

  always_ff @(posedge clk) begin
    if (rst || lfsr_load) begin
      misr <= '0;
    end else if (state == CHECK) begin
      misr <= {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0)
              ^ {7'b0, cout_in, sum_in};
    end
  end

  assign signature = misr;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: behavioural adder with injectable faults, vector scoreboard.
module tb_adder_bist_checker;

  localparam int N1 = 4;
  localparam int S1 = 2;
  localparam int N2 = 300;
  localparam int S2 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;

  logic [7:0]  a, b, sum_in;
  logic        cin, cout_in;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [15:0] first_fail_idx, signature;

  logic [7:0]  a2, b2;
  logic        cin2;
  logic [7:0]  sum2;
  logic        cout2;
  logic        busy2, done2, pass2;
  logic [7:0]  err_count2;
  logic [15:0] first_fail_idx2, signature2;

  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          fault_mode = 0;

  always #5 clk = ~clk;

  // Behavioural adder under test: 0 golden, 1 sum[0] stuck-at-0, 2 sum[7] stuck-at-1.
  function automatic logic [8:0] model_resp(input logic [7:0] x, input logic [7:0] y,
                                            input logic c, input int mode);
    logic [8:0] r;
    r = {1'b0, x} + {1'b0, y} + {8'b0, c};
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r[7] = 1'b1;
    return r;
  endfunction

  function automatic logic [16:0] lfsr_next(input logic [16:0] v);
    return {v[15:0], v[16] ^ v[13]};
  endfunction

  always_comb begin
    {cout_in, sum_in} = model_resp(a, b, cin, fault_mode);
  end

  assign sum2  = 8'h00;
  assign cout2 = 1'b0;

  adder_bist_checker #(.N_VECTORS(N1), .SETTLE_CYCLES(S1), .SEED(17'h00001)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin), .sum_in(sum_in), .cout_in(cout_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .signature(signature)
  );

  adder_bist_checker #(.N_VECTORS(N2), .SETTLE_CYCLES(S2), .SEED(17'h00000)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .cin(cin2), .sum_in(sum2), .cout_in(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_fail_idx(first_fail_idx2), .signature(signature2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Queue the run's vectors and derive the expected error summary for fault_mode.
  task automatic load_vectors(input int n, input int mode, output int exp_err, output int exp_ff);
    logic [16:0] v;
    v = 17'h00001;
    exp_err = 0;
    exp_ff  = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      if (model_resp(v[7:0], v[15:8], v[16], mode) != ({1'b0, v[7:0]} + {1'b0, v[15:8]} + {8'b0, v[16]})) begin
        if (exp_err < 255) exp_err++;
        if (exp_ff == 16'hFFFF) exp_ff = i;
      end
      v = lfsr_next(v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pop_vec(input string tag, input logic [16:0] got);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " queue_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // One run on dut. stop_at > 0 asserts rst after that cycle and returns early.
  task automatic run1(input string tag, input int mode, input bit poke_start,
                      input int stop_at, output logic [15:0] sig_out);
    int exp_err, exp_ff, cyc, k;
    fault_mode = mode;
    load_vectors(N1, mode, exp_err, exp_ff);
    pulse_start();
    check({tag, " busy_after_start"}, busy, 1'b1);
    cyc = 0;
    k   = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (poke_start && cyc == 6) start = 1'b1;
      if (poke_start && cyc == 7) start = 1'b0;
      if (k < N1 && cyc == 1 + k * (S1 + 2)) begin
        pop_vec($sformatf("%s vec%0d", tag, k), {cin, b, a});
        k++;
      end
      if (stop_at > 0 && cyc == stop_at) begin
        rst = 1'b1;
        sig_out = signature;
        return;
      end
    end
    check({tag, " done_seen"}, done, 1'b1);
    check({tag, " done_cycle"}, cyc, N1 * (S1 + 2) + 1);
    check({tag, " busy_at_done"}, busy, 1'b0);
    check({tag, " err_count"}, err_count, exp_err);
    check({tag, " first_fail_idx"}, first_fail_idx, exp_ff);
    check({tag, " pass"}, pass, (exp_err == 0));
    check({tag, " queue_drained"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done_held"}, done, 1'b1);
    check({tag, " err_held"}, err_count, exp_err);
    check({tag, " ff_held"}, first_fail_idx, exp_ff);
    sig_out = signature;
  endtask

  initial begin
    logic [15:0] sig_a, sig_b, sig_c, sig_x;
    int exp_err, exp_ff, cyc;

    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst a", a, 8'h00);
    check("rst b", b, 8'h00);
    check("rst cin", cin, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst pass", pass, 1'b0);
    check("rst err_count", err_count, 8'h00);
    check("rst first_fail_idx", first_fail_idx, 16'hFFFF);
    check("rst signature", signature, 16'h0000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run1("golden1", 0, 1'b0, 0, sig_a);
    run1("golden2", 0, 1'b0, 0, sig_b);
    run1("sum0_sa0", 1, 1'b0, 0, sig_x);
    run1("sum7_sa1", 2, 1'b0, 0, sig_c);
`ifdef BIST_SIGNATURE_EN
    check("sig repeatable", sig_b, sig_a);
    check("sig nonzero", (sig_a != 16'h0), 1'b1);
    check("sig detects fault", (sig_c != sig_a), 1'b1);
`else
    check("sig tied golden", sig_a, 16'h0000);
    check("sig tied faulty", sig_c, 16'h0000);
`endif

    run1("start_while_busy", 0, 1'b1, 0, sig_x);

    // Reset during WAIT of vector 2 (its DRIVE edge is cycle 9).
    run1("mid_rst", 0, 1'b0, 9, sig_x);
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst done", done, 1'b0);
    check("mid_rst a", a, 8'h00);
    check("mid_rst b", b, 8'h00);
    check("mid_rst cin", cin, 1'b0);
    check("mid_rst err_count", err_count, 8'h00);
    check("mid_rst first_fail_idx", first_fail_idx, 16'hFFFF);
    exp_q.delete();
    run1("after_rst", 0, 1'b0, 0, sig_x);

    // start coincident with rst must not launch a run.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start busy", busy, 1'b0);
    check("rst_start done", done, 1'b0);

    // Long run, no settle cycles, adder returning zero, SEED=0 falls back to 1.
    load_vectors(1, 0, exp_err, exp_ff);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("zero busy_after_start", busy2, 1'b1);
    cyc = 0;
    while (!done2 && cyc < 800) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 1) pop_vec("zero vec0", {cin2, b2, a2});
    end
    check("zero done_seen", done2, 1'b1);
    check("zero done_cycle", cyc, N2 * (S2 + 2) + 1);
    check("zero err_count", err_count2, 8'd255);
    check("zero first_fail_idx", first_fail_idx2, 16'h0000);
    check("zero pass", pass2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
